gpio_ctrl: RTL and testbench
============================

Name: gpio_ctrl

Overview:
- Register-mapped sequencer that owns the enable, direction and output-data controls of the 8-bit GPIO pin block.
- Sits between the core's simple request/response bus and the GPIO pins.
- Serialises accesses and inserts a safe turnaround when pins change from input to output.
- Provides a two-flop synchronised, masked view of pin inputs.

Parameters:
WIDTH, 8, number of GPIO pins controlled
TURN_CYCLES, 2, cycles pins stay disabled during an input-to-output turnaround; legal range 1..15

Ports:
clk  input  1  clock
rst  input  1  reset
req_valid  input  1  request present
req_ready  output  1  request accepted when high together with req_valid
req_we  input  1  1 = write, 0 = read
req_addr  input  2  register select: 0 OUT, 1 DIR, 2 EN, 3 IN
req_wdata  input  WIDTH  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  WIDTH  read data; valid only with rsp_valid, 0 otherwise
pin_in  input  WIDTH  raw asynchronous pin input levels
gpio_en  output  WIDTH  per-pin enable
gpio_dir  output  WIDTH  per-pin direction, 1 = input, 0 = output
gpio_out  output  WIDTH  output data, masked by en & ~dir
busy  output  1  state != IDLE

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - gpio_en = 0, gpio_dir = all ones (all inputs), out register = 0, gpio_out = 0.
  - rsp_valid = 0, rsp_rdata = 0, sync flops = 0, state IDLE.
- gpio_out = out_reg & gpio_en & ~gpio_dir. Registered; updates in the same cycle as the controlling register.
- req_ready = (state == IDLE). Combinational; high the cycle after reset deasserts.
- One outstanding request at a time; no backpressure on the response side.
- FSM states: IDLE, EXEC, TURN, RESP.
  - IDLE: on accept, latch we/addr/wdata, go to EXEC.
  - EXEC, write OUT: out_reg <= wdata, go to RESP.
  - EXEC, write EN: gpio_en <= wdata, go to RESP.
  - EXEC, write DIR: compute flip = gpio_en & gpio_dir & ~wdata (enabled inputs becoming outputs).
    - If flip == 0: gpio_dir <= wdata, go to RESP.
    - Else: gpio_en <= gpio_en & ~flip, gpio_dir <= wdata, load counter with TURN_CYCLES, go to TURN.
  - EXEC, read: capture the selected value into the response register, go to RESP.
    - Addresses 0..2 return the register value.
    - Address 3 returns sync_in & gpio_en & gpio_dir.
  - EXEC, write to address 3: no effect except the optional feature below; go to RESP.
  - TURN: decrement counter each cycle. When the counter reaches 1, restore the flip bits in gpio_en and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
    - rsp_rdata = captured value for reads, 0 for writes.
- Latency, request accepted at edge N:
  - No turnaround: rsp_valid is high during the cycle after edge N+2.
  - Turnaround: TURN_CYCLES additional cycles.
- Input synchroniser: two-flop chain on pin_in, clocked every cycle independent of the FSM. Read latency from a pin change is 2 cycles plus the bus latency.
- Output-to-input changes, and direction changes on disabled pins, take effect immediately without turnaround.
- Reset in any state, including mid-TURN: immediate return to reset values, no response issued, and the in-flight request is dropped.
- req_valid while busy: ignored. The requester must hold it until accepted.

Optional Feature:
- Macro: GPIO_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and an internal irq_status register (WIDTH bits, reset 0).
  - Each cycle: irq_status |= sync_in & ~sync_prev & gpio_en & gpio_dir (rising edges on enabled inputs only).
  - Write to address 3 clears status bits written as 1 (write-1-to-clear). If a set and a clear hit the same bit in the same cycle, the set wins.
  - irq = |irq_status, registered.
  - Read of address 3 is unchanged.
- Not defined: no irq port, no status logic, and writes to address 3 are ignored.

Test Plan:
- Reset, then read DIR, EN, OUT -> rsp_rdata = 0xFF, 0x00, 0x00; req_ready = 1 the cycle after reset deasserts.
- Write EN = 0x0F, then DIR = 0xF0 with TURN_CYCLES = 2:
  - gpio_en drops to 0x00 for exactly 2 cycles, then returns to 0x0F.
  - rsp_valid arrives 4 cycles after accept.
  - Write OUT = 0xA5 -> gpio_out = 0x05.
- Write DIR 0xF0 -> 0xFF with EN = 0xFF -> no TURN state; rsp_valid 2 cycles after accept; gpio_out = 0x00.
- Set EN = 0xFF, DIR = 0xFF, drive pin_in = 0x3C -> read IN returns 0x3C. With EN = 0x0F, the same read returns 0x0C.
- Assert rst during TURN -> gpio_en = 0, gpio_dir = 0xFF, and no rsp_valid is seen.
- GPIO_IRQ_EN: with EN = DIR = 0xFF, pin_in bit 2 rising -> irq = 1 within 4 cycles. Write 0x04 to address 3 -> irq = 0. An edge coinciding with the clear leaves irq = 1.

Source files
------------

// File: rtl/gpio_ctrl_if.sv
// Request/response bus between the core and the GPIO sequencer.
interface gpio_ctrl_if #(parameter int WIDTH = 8);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO pin sequencer: OUT/DIR/EN/IN registers with input-to-output turnaround.
// Define GPIO_IRQ_EN to add rising-edge interrupt status (W1C at address 3) and irq.
module gpio_ctrl_lane (
    input  logic clk,
    input  logic rst,
    input  logic pin,
`ifdef GPIO_IRQ_EN
    input  logic en,
    input  logic dir,
    input  logic clr,
    output logic st,
`endif
    output logic sync
);
    logic s1;
`ifdef GPIO_IRQ_EN
    logic prev;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            sync <= 1'b0;
`ifdef GPIO_IRQ_EN
            prev <= 1'b0;
            st   <= 1'b0;
`endif
        end else begin
            s1   <= pin;
            sync <= s1;
`ifdef GPIO_IRQ_EN
            prev <= sync;
            // set has priority over a same-cycle clear
            st   <= (st & ~clr) | (sync & ~prev & en & dir);
`endif
        end
    end
endmodule

module gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] gpio_en,
    output logic [WIDTH-1:0] gpio_dir,
    output logic [WIDTH-1:0] gpio_out,
`ifdef GPIO_IRQ_EN
    output logic             irq,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, TURN, RESP} state_t;

    state_t           state;
    logic             we_q;
    logic [1:0]       addr_q;
    logic [WIDTH-1:0] wdata_q, out_reg, flip_q, rd_cap, rsp_rdata_q;
    logic             rsp_valid_q;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] sync_in, flip, en_nxt, dir_nxt, out_nxt;

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = (state != IDLE);

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] clr, irq_st;
    assign clr = (state == EXEC && we_q && addr_q == 2'd3) ? wdata_q : '0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_ctrl_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .pin  (pin_in[i]),
`ifdef GPIO_IRQ_EN
            .en   (gpio_en[i]),
            .dir  (gpio_dir[i]),
            .clr  (clr[i]),
            .st   (irq_st[i]),
`endif
            .sync (sync_in[i])
        );
    end

`ifdef GPIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) irq <= 1'b0;
        else     irq <= |irq_st;
    end
`endif

    // Next values of the pin controls, shared so gpio_out tracks them in the same cycle.
    always_comb begin
        en_nxt  = gpio_en;
        dir_nxt = gpio_dir;
        out_nxt = out_reg;
        flip    = gpio_en & gpio_dir & ~wdata_q;
        case (state)
            EXEC: if (we_q) begin
                case (addr_q)
                    2'd0: out_nxt = wdata_q;
                    2'd1: begin
                        dir_nxt = wdata_q;
                        en_nxt  = gpio_en & ~flip;
                    end
                    2'd2: en_nxt = wdata_q;
                    default: ;
                endcase
            end
            TURN: if (cnt == 4'd1) en_nxt = gpio_en | flip_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            out_reg     <= '0;
            gpio_en     <= '0;
            gpio_dir    <= '1;
            gpio_out    <= '0;
            flip_q      <= '0;
            cnt         <= '0;
            rd_cap      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            gpio_en     <= en_nxt;
            gpio_dir    <= dir_nxt;
            out_reg     <= out_nxt;
            gpio_out    <= out_nxt & en_nxt & ~dir_nxt;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    state   <= EXEC;
                end
                EXEC: begin
                    rd_cap <= '0;
                    state  <= RESP;
                    if (!we_q) begin
                        case (addr_q)
                            2'd0:    rd_cap <= out_reg;
                            2'd1:    rd_cap <= gpio_dir;
                            2'd2:    rd_cap <= gpio_en;
                            default: rd_cap <= sync_in & gpio_en & gpio_dir;
                        endcase
                    end else if (addr_q == 2'd1 && flip != '0) begin
                        flip_q <= flip;
                        cnt    <= TURN_CYCLES[3:0];
                        state  <= TURN;
                    end
                end
                TURN: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_cap;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: expected responses queued at issue, checked on rsp_valid.
`timescale 1ns/1ps
module tb_gpio_ctrl;
  localparam int W    = 8;
  localparam int TURN = 2;

  typedef struct { logic [W-1:0] rd; int due; } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] pin_in = '0;
  logic [W-1:0] gpio_en, gpio_dir, gpio_out;
  logic         busy;
`ifdef GPIO_IRQ_EN
  logic         irq;
`endif

  gpio_ctrl_if #(.WIDTH(W)) b();

  gpio_ctrl #(.WIDTH(W), .TURN_CYCLES(TURN)) dut (
    .clk(clk), .rst(rst), .bus(b), .pin_in(pin_in),
    .gpio_en(gpio_en), .gpio_dir(gpio_dir), .gpio_out(gpio_out),
`ifdef GPIO_IRQ_EN
    .irq(irq),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int   checks = 0, errors = 0, cyc = 0, ez = 0, nrsp = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy && gpio_en == '0) ez++;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (b.rsp_valid) begin
        nrsp++;
        if (sbq.size() == 0) chk("rsp_unexp", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("rdata", b.rsp_rdata, e.rd);
          chk("lat", cyc, e.due);
        end
      end else chk("rdata_idle", b.rsp_rdata, 0);
    end
  end

  // Called just after a negedge; returns at a negedge after the response.
  task automatic xfer(input logic we, input logic [1:0] a, input logic [W-1:0] wd,
                      input logic [W-1:0] rd, input int lat);
    int n; exp_t e;
    b.req_valid = 1'b1; b.req_we = we; b.req_addr = a; b.req_wdata = wd;
    n = 0;
    while (!b.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!b.req_ready) begin chk("rdy_to", 0, 1); b.req_valid = 1'b0; return; end
    e.rd = rd; e.due = cyc + 1 + lat; sbq.push_back(e);
    @(negedge clk);
    b.req_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin chk("rsp_to", sbq.size(), 0); sbq.delete(); end
  endtask

  initial begin
    int ez0, n0;
    b.req_valid = 1'b0; b.req_we = 1'b0; b.req_addr = '0; b.req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", b.req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_en", gpio_en, 8'h00);
    chk("rst_dir", gpio_dir, 8'hFF);
    chk("rst_out", gpio_out, 8'h00);
    chk("rst_rsp", b.rsp_valid, 0);

    xfer(0, 2'd1, 0, 8'hFF, 2);
    xfer(0, 2'd2, 0, 8'h00, 2);
    xfer(0, 2'd0, 0, 8'h00, 2);

    // input-to-output turnaround on enabled pins
    xfer(1, 2'd2, 8'h0F, 0, 2);
    ez0 = ez;
    xfer(1, 2'd1, 8'hF0, 0, 2 + TURN);
    chk("turn_en_low", ez - ez0, TURN);
    chk("turn_en", gpio_en, 8'h0F);
    chk("turn_dir", gpio_dir, 8'hF0);
    xfer(1, 2'd0, 8'hA5, 0, 2);
    chk("out_mask", gpio_out, 8'h05);

    // output-to-input: no turnaround
    xfer(1, 2'd2, 8'hFF, 0, 2);
    chk("out_en_ff", gpio_out, 8'h05);
    ez0 = ez;
    xfer(1, 2'd1, 8'hFF, 0, 2);
    chk("noturn_en_low", ez - ez0, 0);
    chk("noturn_out", gpio_out, 8'h00);
    chk("noturn_dir", gpio_dir, 8'hFF);

    // synchronised, masked input
    pin_in = 8'h3C;
    repeat (3) @(negedge clk);
    xfer(0, 2'd3, 0, 8'h3C, 2);
    xfer(1, 2'd2, 8'h0F, 0, 2);
    xfer(0, 2'd3, 0, 8'h0C, 2);
    xfer(0, 2'd2, 0, 8'h0F, 2);
    xfer(1, 2'd3, 8'hFF, 0, 2);
    chk("a3_en", gpio_en, 8'h0F);
    chk("a3_dir", gpio_dir, 8'hFF);
    xfer(0, 2'd0, 0, 8'hA5, 2);

`ifdef GPIO_IRQ_EN
    xfer(1, 2'd2, 8'hFF, 0, 2);
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    xfer(1, 2'd3, 8'hFF, 0, 2);
    chk("irq_clr_all", irq, 0);
    pin_in = 8'h04;
    n0 = 0;
    while (!irq && n0 < 4) begin @(negedge clk); n0++; end
    chk("irq_rise", irq, 1);
    xfer(1, 2'd3, 8'h04, 0, 2);
    chk("irq_w1c", irq, 0);
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    chk("irq_fall", irq, 0);
    pin_in = 8'h04;
    @(negedge clk);
    xfer(1, 2'd3, 8'h04, 0, 2);
    chk("irq_set_wins", irq, 1);
`endif

    // reset mid-turnaround drops the request
    xfer(1, 2'd2, 8'h0F, 0, 2);
    n0 = nrsp;
    b.req_valid = 1'b1; b.req_we = 1'b1; b.req_addr = 2'd1; b.req_wdata = 8'h00;
    @(negedge clk);
    b.req_valid = 1'b0;
    @(negedge clk);
    chk("midturn_en", gpio_en, 8'h00);
    chk("midturn_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_en", gpio_en, 8'h00);
    chk("rst2_dir", gpio_dir, 8'hFF);
    chk("rst2_out", gpio_out, 8'h00);
    chk("rst2_busy", busy, 0);
    repeat (8) @(negedge clk);
    chk("rst2_norsp", nrsp - n0, 0);
    xfer(0, 2'd0, 0, 8'h00, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
